// File: rtl/sum_nbit_sequencer.sv
// sum_nbit_sequencer: parallel-to-serial driver and serial-to-parallel collector
// wrapped around a bit-serial adder core. Rev 1.0
`default_nettype none

module sum_nbit_sequencer #(
    parameter int N   = 8,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] g_word,
    input  logic [N-1:0] e_word,
    output logic         ready,
    output logic         core_rst,
    output logic         g_bit,
    output logic         e_bit,
    input  logic         core_o,
    output logic [N-1:0] result,
    output logic         done
);

    localparam int CW = $clog2(N + LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [N-1:0]  g_sh;
    logic [N-1:0]  e_sh;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cap_idx;
    logic          accept;
    logic          cap_en;
    logic          last_shift;
    logic          last_drain;

    assign accept     = (state == S_IDLE) && ready && start;
    assign last_shift = (cnt == CW'(N - 1));
    assign last_drain = (cnt == CW'(N + LAT - 1));
    // cnt runs through SHIFT and DRAIN; the capture index trails it by LAT.
    assign cap_idx    = cnt - CW'(LAT);

    generate
        if (LAT == 0) begin : g_cap_direct
            assign cap_en = (state == S_SHIFT);
        end else begin : g_cap_delayed
            assign cap_en = ((state == S_SHIFT) || (state == S_DRAIN))
                            && (cnt >= CW'(LAT));
        end
    endgenerate

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_CLR;
            S_CLR:   state_nx = S_SHIFT;
            S_SHIFT: if (last_shift) state_nx = (LAT > 0) ? S_DRAIN : S_DONE;
            S_DRAIN: if (last_drain) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            ready    <= 1'b0;
            done     <= 1'b0;
            core_rst <= 1'b1;
            g_bit    <= 1'b0;
            e_bit    <= 1'b0;
            result   <= '0;
            cnt      <= '0;
            g_sh     <= '0;
            e_sh     <= '0;
        end else begin
            state    <= state_nx;
            ready    <= (state_nx == S_IDLE);
            done     <= (state_nx == S_DONE);
            core_rst <= (state_nx == S_CLR);
            g_bit    <= 1'b0;
            e_bit    <= 1'b0;

            if (accept) begin
                g_sh   <= g_word;
                e_sh   <= e_word;
                cnt    <= '0;
                result <= '0;
            end

            if (state_nx == S_SHIFT) begin
                g_bit <= g_sh[0];
                e_bit <= e_sh[0];
                g_sh  <= g_sh >> 1;
                e_sh  <= e_sh >> 1;
            end

            if ((state == S_SHIFT) || (state == S_DRAIN))
                cnt <= cnt + CW'(1);

            for (int i = 0; i < N; i++) begin
                if (cap_en && (cap_idx == CW'(i)))
                    result[i] <= core_o;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/sum_nbit_sequencer.md
# sum_nbit_sequencer

Parallel-to-serial front end for the bit-serial adder core `sum_nbit_ncc` (ports `clk`, `rst`, `g_input`, `e_input`, `o`).
- Accepts two N-bit operand words with a start/ready handshake.
- Clears the core, then streams operand bits LSB-first, one bit per clock.
- Collects the core's serial sum bits back into an N-bit result word and signals completion with a one-cycle `done` pulse.
- Plays the driver/collector role around the serial core.

## Interface
- `N`, 8: operand and result width in bits, N ≥ 2.
- `LAT`, 1: core output latency in cycles, from a bit pair presented on `g_bit`/`e_bit` to the matching sum bit on `core_o`. Legal range 0..2.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset: synchronous, active-low.
- `start`  in  1  request a new addition; accepted only when `ready` = 1.
- `g_word`  in  N  garbler operand; sampled on the accepting edge.
- `e_word`  in  N  evaluator operand; sampled on the accepting edge.
- `ready`  out  1  block is idle and will accept `start`.
- `core_rst`  out  1  active-high clear to the serial core's `rst`.
- `g_bit`  out  1  serial garbler bit, drives core `g_input`.
- `e_bit`  out  1  serial evaluator bit, drives core `e_input`.
- `core_o`  in  1  serial sum bit from core `o`.
- `result`  out  N  assembled sum, (G + E) mod 2^N.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle onward.

## Operation
**Reset.** While `rst` = 0 at an edge:
- state becomes IDLE.
- `ready` = 0, `done` = 0, `g_bit` = `e_bit` = 0, `result` = 0.
- `core_rst` = 1, holding the core cleared.

From the first edge with `rst` = 1:
- `ready` = 1, `core_rst` = 0.

**States.**
- **IDLE**
  - `ready` = 1.
  - When `start` = 1, latch `g_word`/`e_word` into shift registers, clear the bit counter and go to CLR.
- **CLR** (1 cycle)
  - `core_rst` = 1, `g_bit` = `e_bit` = 0, `ready` = 0. Go to SHIFT.
- **SHIFT** (N cycles, k = 0..N-1)
  - `g_bit` = G[k], `e_bit` = E[k], `core_rst` = 0.
  - After k = N-1, go to DRAIN if LAT > 0, otherwise go to DONE.
- **DRAIN** (LAT cycles)
  - `g_bit` = `e_bit` = 0. Keep capturing outstanding sum bits.
- **DONE** (1 cycle)
  - `done` = 1, `ready` = 0. Go to IDLE.

**Capture.**
- Sum bit k appears on `core_o` LAT cycles after SHIFT cycle k.
- It is written to `result[k]` at the end of that cycle, using a separate capture index that trails the drive index by LAT.
- Exactly N bits are captured. Bits presented during CLR or DRAIN are never captured.

**Result register.**
- `result` holds its value from DONE until the next accepted `start`.
- It is cleared to 0 on the accepting edge; partially built values are visible during the operation.
- No carry-out is produced; the sum wraps mod 2^N.

**Boundary conditions.**
- `start` while `ready` = 0 is ignored, with no queuing.
- Operand inputs changing after acceptance have no effect.
- `start` held high continuously is accepted again in the first IDLE cycle after DONE.
- `rst` low mid-operation aborts immediately to the reset values above, so the core is re-cleared. A `done` pulse is never emitted for an aborted operation.
- LAT = 0: DRAIN is skipped and `core_o` is captured in the same cycle its bits are driven.

## Timing
- Cycle 0 is the cycle in which `start` = 1 and `ready` = 1 are sampled.
- Cycle 1: CLR.
- Cycles 2..N+1: SHIFT.
- Cycles N+2..N+1+LAT: DRAIN.
- Cycle N+2+LAT: DONE, `done` = 1.
- Cycle N+3+LAT: `ready` = 1.
- Throughput: one addition per N+3+LAT cycles; 12 cycles for N=8, LAT=1.
- All outputs are registered. The only combinational input path is `core_o` into the capture register.

## Test plan
The bench instantiates the block together with a behavioral serial adder: carry register cleared by `core_rst`, registered sum output with LAT = 1.
- G=A9, E=7B, start pulse -> `done` at cycle 11, `result` = 24; `ready` returns at cycle 12.
- G=18, E=27, then G=57, E=63 with `start` held high throughout -> `result` = 3F at the first `done`, BA at the second; the second `done` arrives 12 cycles after the first.
- G=FF, E=01 -> `result` = 00 (wrap); G=00, E=00 -> `result` = 00; `done` timing unchanged.
- Start G=A9, E=7B, then pulse `start` with G=11, E=22 in cycle 5 -> second request ignored; `result` = 24 with a single `done`.
- Start G=A9, E=7B; drive `rst` = 0 in cycle 6 for one cycle -> next cycle `ready` = 1, `result` = 00, no `done`. Then start G=18, E=27 -> `result` = 3F, unaffected by stale core carry.
- Re-run with LAT = 0 and LAT = 2 (core model matched) and G=57, E=63 -> `result` = BA, `done` at cycle 10 and cycle 12 respectively.
